// File: rtl/ball_bounce_multi.sv
// ============================================================================
// Module      : ball_bounce_multi
// Description : NUM_BALLS bouncing square balls, advanced once per frame on the
//               vsync assertion edge and rendered as a registered 3-bit colour.
//               Optional macro BALL_COLLIDE_EN adds a per-frame overlap flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_bounce_multi #(
    parameter int NUM_BALLS        = 2,
    parameter int BALL_SIZE        = 8,
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int VEL_WIDTH        = 4,
    parameter int VSYNC_ACTIVE_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vsync,
    input  logic       i_visible,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    output logic [2:0] o_rgb,
    output logic       o_busy,
    output logic       o_collide
);

    localparam int         c_KW     = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [9:0] c_MAX_X  = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] c_MAX_Y  = 10'(V_ACTIVE - BALL_SIZE);
    localparam logic [9:0] c_SIZE   = 10'(BALL_SIZE);
    localparam logic       c_VS_POL = (VSYNC_ACTIVE_LOW != 0);
    localparam int         c_VMSB   = VEL_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UPD_X = 2'd1,
        S_UPD_Y = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [c_KW-1:0]             r_k;
    logic [c_KW-1:0]             w_k_next;
    logic                        w_busy;

    logic                        w_vs_act;
    logic                        r_vs_act_d;
    logic                        w_tick;

    logic [9:0]                  r_x  [NUM_BALLS];
    logic [9:0]                  r_y  [NUM_BALLS];
    logic signed [VEL_WIDTH-1:0] r_vx [NUM_BALLS];
    logic signed [VEL_WIDTH-1:0] r_vy [NUM_BALLS];

    logic                        w_is_y;
    logic [9:0]                  w_pos;
    logic signed [VEL_WIDTH-1:0] w_vel;
    logic signed [VEL_WIDTH-1:0] w_neg_vel;
    logic [9:0]                  w_max;
    logic [VEL_WIDTH-1:0]        w_mag;
    logic [10:0]                 w_sum;
    logic [9:0]                  w_diff;
    logic [9:0]                  w_new_pos;
    logic signed [VEL_WIDTH-1:0] w_new_vel;

    logic [NUM_BALLS-1:0]        w_hit;
    logic [2:0]                  w_col;
    logic [2:0]                  r_rgb;

    // Sync edge detection, normalised to an active-high pulse
    assign w_vs_act = i_vsync ^ c_VS_POL;
    assign w_tick   = w_vs_act & ~r_vs_act_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_act_d <= 1'b0;
        end else begin
            r_vs_act_d <= w_vs_act;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_next = S_UPD_X;
                    w_k_next     = '0;
                end
            end
            S_UPD_X: begin
                w_busy       = 1'b1;
                w_state_next = S_UPD_Y;
            end
            S_UPD_Y: begin
                w_busy = 1'b1;
                if (r_k == c_KW'(NUM_BALLS - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_k_next     = r_k + 1'b1;
                    w_state_next = S_UPD_X;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_busy = w_busy;

    // Select the axis of ball k that the current state is updating
    always_comb begin
        w_is_y = (r_state == S_UPD_Y);
        w_pos  = r_x[0];
        w_vel  = r_vx[0];
        for (int i = 0; i < NUM_BALLS; i++) begin
            if (r_k == c_KW'(i)) begin
                w_pos = w_is_y ? r_y[i]  : r_x[i];
                w_vel = w_is_y ? r_vy[i] : r_vx[i];
            end
        end
        w_max = w_is_y ? c_MAX_Y : c_MAX_X;
    end

    // Wall reflection; the 11-bit sum keeps an overshoot from wrapping
    always_comb begin
        w_neg_vel = -w_vel;
        w_mag     = w_vel[c_VMSB] ? $unsigned(w_neg_vel) : $unsigned(w_vel);
        w_sum     = {1'b0, w_pos} + 11'(w_mag);
        w_diff    = w_pos - 10'(w_mag);
        w_new_vel = w_vel;
        if (!w_vel[c_VMSB] && (w_vel != '0) && (w_sum > {1'b0, w_max})) begin
            w_new_pos = w_max;
            w_new_vel = w_neg_vel;
        end else if (w_vel[c_VMSB] && (w_pos < 10'(w_mag))) begin
            w_new_pos = '0;
            w_new_vel = w_neg_vel;
        end else if (w_vel[c_VMSB]) begin
            w_new_pos = w_diff;
        end else begin
            w_new_pos = w_sum[9:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_x[i]  <= 10'(64 + 128 * i);
                r_y[i]  <= 10'(48 + 96 * i);
                r_vx[i] <= VEL_WIDTH'(i + 1);
                r_vy[i] <= ((i % 2) == 0) ? VEL_WIDTH'(i + 1) : VEL_WIDTH'(-(i + 1));
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (r_k == c_KW'(i)) begin
                    if (r_state == S_UPD_X) begin
                        r_x[i]  <= w_new_pos;
                        r_vx[i] <= w_new_vel;
                    end
                    if (r_state == S_UPD_Y) begin
                        r_y[i]  <= w_new_pos;
                        r_vy[i] <= w_new_vel;
                    end
                end
            end
        end
    end

    // Unsigned wrap makes pixels left of / above a ball fail the range test
    generate
        for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_hit
            logic [9:0] w_dx;
            logic [9:0] w_dy;
            assign w_dx      = i_hpos - r_x[gi];
            assign w_dy      = i_vpos - r_y[gi];
            assign w_hit[gi] = (w_dx < c_SIZE) && (w_dy < c_SIZE);
        end
    endgenerate

    always_comb begin
        w_col = 3'd0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_col = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb <= 3'd0;
        end else begin
            r_rgb <= i_visible ? w_col : 3'd0;
        end
    end

    assign o_rgb = r_rgb;

`ifdef BALL_COLLIDE_EN
    logic r_coll_sticky;
    logic r_collide;
    logic w_multi_hit;

    assign w_multi_hit = i_visible && ($countones(w_hit) >= 2);

    // The flag for the finished frame is latched at the tick, then restarted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_coll_sticky <= 1'b0;
            r_collide     <= 1'b0;
        end else if (w_tick && (r_state == S_IDLE)) begin
            r_collide     <= r_coll_sticky;
            r_coll_sticky <= 1'b0;
        end else if (w_multi_hit) begin
            r_coll_sticky <= 1'b1;
        end
    end

    assign o_collide = r_collide;
`else
    assign o_collide = 1'b0;
`endif

endmodule

`default_nettype wire
